// File: rtl/rv_regfile_sb_if.sv
// Bus bundle between the issue/writeback logic and rv_regfile_sb.
// Issue side drives the read addresses, the writeback port and reservation requests.
// The register file returns the read data, the hazard flags and the scoreboard status.
//   ra1/ra2     read addresses         rd1/rd2   combinational read data
//   we/wa/wd    writeback port         rsv_*     reservation request at issue
//   busy1/2     pending-write flags    stall     issue must hold
//   rsv_ok      reservation accepted   pend_cnt  busy register count
//   err_unres   sticky write-without-reservation flag
interface rv_regfile_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            busy1;
    logic            busy2;
    logic            stall;
    logic            rsv_ok;
    logic [AW:0]     pend_cnt;
    logic            err_unres;

    modport master (
        output ra1, ra2, we, wa, wd, rsv_en, rsv_addr,
        input  rd1, rd2, busy1, busy2, stall, rsv_ok, pend_cnt, err_unres
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, rsv_en, rsv_addr,
        output rd1, rd2, busy1, busy2, stall, rsv_ok, pend_cnt, err_unres
    );
endinterface

// File: rtl/rv_regfile_sb.sv
// Integer register file with write-pending scoreboard for the pipelined RV32I core.
// Two combinational read ports, one synchronous write port, optional hardwired x0,
// optional write-to-read forwarding and one busy bit per register.
// Ports:
//   clk     rising-edge clock
//   areset  asynchronous active-low reset (clears registers, busy bits and status)
//   bus     rv_regfile_sb_if.slave: reads, writeback, reservation, hazard/status outputs
module rv_regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           areset,
    rv_regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_pend_cnt;
    logic             r_err_unres;

    logic             w_wa_zero;
    logic             w_ra1_zero;
    logic             w_ra2_zero;
    logic             w_rsv_zero;
    logic             w_we_eff;
    logic             w_fwd1;
    logic             w_fwd2;
    logic             w_busy1;
    logic             w_busy2;
    logic             w_waw;
    logic             w_stall;
    logic             w_rsv_ok;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    assign w_wa_zero  = ZERO_REG && (bus.wa == '0);
    assign w_ra1_zero = ZERO_REG && (bus.ra1 == '0);
    assign w_ra2_zero = ZERO_REG && (bus.ra2 == '0);
    assign w_rsv_zero = ZERO_REG && (bus.rsv_addr == '0);
    assign w_we_eff   = bus.we && !w_wa_zero;

    // Forwarding never applies to the zero register: w_we_eff is low for wa==0 then.
    assign w_fwd1 = BYPASS && w_we_eff && (bus.wa == bus.ra1);
    assign w_fwd2 = BYPASS && w_we_eff && (bus.wa == bus.ra2);

    assign w_busy1 = !w_ra1_zero && !w_fwd1 && r_busy[bus.ra1];
    assign w_busy2 = !w_ra2_zero && !w_fwd2 && r_busy[bus.ra2];

    // A pending destination being written back this same cycle is not a WAW hazard:
    // the old owner retires on the edge where the new one reserves.
    assign w_waw = bus.rsv_en && !w_rsv_zero && r_busy[bus.rsv_addr]
                   && !(bus.we && (bus.wa == bus.rsv_addr));

    assign w_stall  = w_busy1 || w_busy2 || w_waw;
    assign w_rsv_ok = bus.rsv_en && !w_stall;

    assign bus.rd1       = w_ra1_zero ? '0 : (w_fwd1 ? bus.wd : r_regs[bus.ra1]);
    assign bus.rd2       = w_ra2_zero ? '0 : (w_fwd2 ? bus.wd : r_regs[bus.ra2]);
    assign bus.busy1     = w_busy1;
    assign bus.busy2     = w_busy2;
    assign bus.stall     = w_stall;
    assign bus.rsv_ok    = w_rsv_ok;
    assign bus.pend_cnt  = r_pend_cnt;
    assign bus.err_unres = r_err_unres;

    // Release first, then reserve, so a same-register reserve on the writeback edge wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we_eff) begin
            w_busy_nxt[bus.wa] = 1'b0;
        end
        if (w_rsv_ok && !w_rsv_zero) begin
            w_busy_nxt[bus.rsv_addr] = 1'b1;
        end
        w_cnt_nxt = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy      <= '0;
            r_pend_cnt  <= '0;
            r_err_unres <= 1'b0;
        end else begin
            if (w_we_eff) begin
                r_regs[bus.wa] <= bus.wd;
            end
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_cnt_nxt;
            if (bus.we && !r_busy[bus.wa] && !w_wa_zero) begin
                r_err_unres <= 1'b1;
            end
        end
    end
endmodule
